// File: rtl/rom_read_arbiter_pkg.sv
// Shared bus constants and helpers for the two-master ROM read arbiter.
package rom_read_arbiter_pkg;

    localparam int AV_DATA_W        = 32;
    localparam int MASTER_ID_W      = 1;
    localparam int READ_LATENCY_MAX = 4;

    typedef enum logic [MASTER_ID_W-1:0] {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_id_e;

    // Word address width left after the interconnect strips the slave-select bits.
    function automatic int word_addr_w(input int sel_bits);
        return 30 - sel_bits;
    endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Avalon read-only bus bundle; master drives the command, slave answers with wait and data.
interface rom_read_arbiter_if
    import rom_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = word_addr_w(6)
) ();

    logic                 SlaveSel;
    logic [ADDR_W-1:0]    RegAddr;
    logic                 Read;
    logic                 WaitRequest;
    logic [AV_DATA_W-1:0] ReadData;
    logic                 ReadDataValid;

    // Fixed-latency memory slaves never drive ReadDataValid, so the master side omits it.
    modport master (
        output SlaveSel, RegAddr, Read,
        input  WaitRequest, ReadData
    );

    modport slave (
        input  SlaveSel, RegAddr, Read,
        output WaitRequest, ReadData, ReadDataValid
    );

endinterface

// File: rtl/rom_read_arbiter_return_pipe.sv
// Fixed-depth shift register recording which master owns each in-flight read.
module avalon_return_pipe #(
    parameter int DEPTH = 1,
    parameter int ID_W  = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            vld_i,
    input  logic [ID_W-1:0] id_i,
    output logic            vld_o,
    output logic [ID_W-1:0] id_o
);

    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = vld_i;
        id_d[0]  = id_i;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign id_o  = id_q[DEPTH-1];

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Avalon read slave between two read masters,
// steering each returned word back to the master that issued it.
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int ADDR_SEL_BITS = 6,
    parameter int READ_LATENCY  = 1
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    rom_read_arbiter_if.slave  m0_if,
    rom_read_arbiter_if.slave  m1_if,
    rom_read_arbiter_if.master s_if
);

    localparam int ADDR_W = word_addr_w(ADDR_SEL_BITS);
    // Out-of-range latencies are clamped so the return pipe always has a legal depth.
    localparam int PIPE_DEPTH = (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                                (READ_LATENCY < 1)                ? 1 : READ_LATENCY;

    master_id_e              prio_q, prio_d;
    master_id_e              winner;
    logic                    req0, req1, any_req, accept;
    logic [ADDR_W-1:0]       win_addr;
    logic                    ret_vld;
    logic [MASTER_ID_W-1:0]  ret_id;

    // Requests are masked during reset so the slave sees no command and masters no stall.
    always_comb begin
        req0    = m0_if.SlaveSel & m0_if.Read & i_Reset_n;
        req1    = m1_if.SlaveSel & m1_if.Read & i_Reset_n;
        any_req = req0 | req1;
        accept  = any_req & ~s_if.WaitRequest;

        if (req0 && req1) begin
            winner = prio_q;
        end else if (req1) begin
            winner = MST_M1;
        end else begin
            winner = MST_M0;
        end

        prio_d = prio_q;
        if (accept) begin
            prio_d = (winner == MST_M0) ? MST_M1 : MST_M0;
        end

        win_addr = (winner == MST_M1) ? m1_if.RegAddr : m0_if.RegAddr;
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            prio_q <= MST_M0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign s_if.SlaveSel = any_req;
    assign s_if.Read     = any_req;
    assign s_if.RegAddr  = win_addr;

    assign m0_if.WaitRequest = req0 & ~(accept & (winner == MST_M0));
    assign m1_if.WaitRequest = req1 & ~(accept & (winner == MST_M1));

    avalon_return_pipe #(
        .DEPTH (PIPE_DEPTH),
        .ID_W  (MASTER_ID_W)
    ) u_return_pipe (
        .clk_i  (i_Clk),
        .rst_ni (i_Reset_n),
        .vld_i  (accept),
        .id_i   (winner),
        .vld_o  (ret_vld),
        .id_o   (ret_id)
    );

    assign m0_if.ReadDataValid = ret_vld & (ret_id == MST_M0);
    assign m1_if.ReadDataValid = ret_vld & (ret_id == MST_M1);
    assign m0_if.ReadData      = m0_if.ReadDataValid ? s_if.ReadData : '0;
    assign m1_if.ReadData      = m1_if.ReadDataValid ? s_if.ReadData : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: latency-1 and latency-3 instances checked against a queue-based model.
module tb_rom_read_arbiter;
    import rom_read_arbiter_pkg::*;

    localparam int AW   = 24;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int OW   = 2 + AW + 2 + 2 * 33;
    localparam int B_RD = OW - 1;
    localparam int B_SL = OW - 2;
    localparam int B_W0 = OW - AW - 3;
    localparam int B_W1 = B_W0 - 1;
    localparam int B_V0 = B_W0 - 2;
    localparam int B_V1 = 32;

    typedef logic [OW-1:0] ovec_t;
    typedef struct { int due; int id; logic [31:0] data; } ret_t;
    typedef struct { int due; logic [AW-1:0] addr; } slv_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          st_sel   [2][2];
    logic          st_rd    [2][2];
    logic [AW-1:0] st_addr  [2][2];
    logic          st_wait  [2];
    logic [31:0]   st_rdata [2];

    rom_read_arbiter_if #(.ADDR_W(AW)) ma0 ();
    rom_read_arbiter_if #(.ADDR_W(AW)) ma1 ();
    rom_read_arbiter_if #(.ADDR_W(AW)) sa  ();
    rom_read_arbiter_if #(.ADDR_W(AW)) mb0 ();
    rom_read_arbiter_if #(.ADDR_W(AW)) mb1 ();
    rom_read_arbiter_if #(.ADDR_W(AW)) sb  ();

    assign ma0.SlaveSel = st_sel[0][0];  assign ma0.Read = st_rd[0][0];  assign ma0.RegAddr = st_addr[0][0];
    assign ma1.SlaveSel = st_sel[0][1];  assign ma1.Read = st_rd[0][1];  assign ma1.RegAddr = st_addr[0][1];
    assign mb0.SlaveSel = st_sel[1][0];  assign mb0.Read = st_rd[1][0];  assign mb0.RegAddr = st_addr[1][0];
    assign mb1.SlaveSel = st_sel[1][1];  assign mb1.Read = st_rd[1][1];  assign mb1.RegAddr = st_addr[1][1];
    assign sa.WaitRequest = st_wait[0];  assign sa.ReadData = st_rdata[0];  assign sa.ReadDataValid = 1'b0;
    assign sb.WaitRequest = st_wait[1];  assign sb.ReadData = st_rdata[1];  assign sb.ReadDataValid = 1'b0;

    rom_read_arbiter #(.ADDR_SEL_BITS(6), .READ_LATENCY(LAT0)) dut_l1 (
        .i_Clk(clk), .i_Reset_n(rstn), .m0_if(ma0), .m1_if(ma1), .s_if(sa));
    rom_read_arbiter #(.ADDR_SEL_BITS(6), .READ_LATENCY(LAT1)) dut_l3 (
        .i_Clk(clk), .i_Reset_n(rstn), .m0_if(mb0), .m1_if(mb1), .s_if(sb));

    // Reference model state: favoured master, expected returns, and the memory slave's own queue.
    int   prio [2];
    ret_t rq0[$], rq1[$];
    slv_t sq0[$], sq1[$];
    int   cyc, n_chk, n_fail;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (a == 5) return 32'hDEADBEEF;
        return {a[7:0] ^ 8'h3C, a};
    endfunction

    function automatic ovec_t observe(input int d);
        if (d == 0)
            return {sa.Read, sa.SlaveSel, sa.RegAddr, ma0.WaitRequest, ma1.WaitRequest,
                    ma0.ReadDataValid, ma0.ReadData, ma1.ReadDataValid, ma1.ReadData};
        return {sb.Read, sb.SlaveSel, sb.RegAddr, mb0.WaitRequest, mb1.WaitRequest,
                mb0.ReadDataValid, mb0.ReadData, mb1.ReadDataValid, mb1.ReadData};
    endfunction

    function automatic bit req_of(input int d, input int m);
        return rstn && st_sel[d][m] && st_rd[d][m];
    endfunction

    // -1 when nobody requests; otherwise the master that should own the slave this cycle.
    function automatic int win_of(input int d);
        bit r0, r1;
        r0 = req_of(d, 0);
        r1 = req_of(d, 1);
        if (r0 && r1) return prio[d];
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic bit ret_head(input int d, output ret_t h);
        h = '{due: 0, id: 0, data: '0};
        if (d == 0 && rq0.size() > 0) begin h = rq0[0]; return 1'b1; end
        if (d == 1 && rq1.size() > 0) begin h = rq1[0]; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic ovec_t expect_vec(input int d);
        int          w;
        bit          acc, r0, r1, v0, v1;
        logic [31:0] d0, d1;
        ret_t        h;
        w   = win_of(d);
        acc = (w >= 0) && !st_wait[d];
        r0  = req_of(d, 0);
        r1  = req_of(d, 1);
        v0  = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        if (rstn && ret_head(d, h) && h.due == cyc) begin
            if (h.id == 0) begin v0 = 1'b1; d0 = h.data; end
            else           begin v1 = 1'b1; d1 = h.data; end
        end
        return {w >= 0, w >= 0, (w == 1) ? st_addr[d][1] : st_addr[d][0],
                r0 && !(acc && w == 0), r1 && !(acc && w == 1), v0, d0, v1, d1};
    endfunction

    task automatic set_req(input int d, input bit r0, input logic [AW-1:0] a0,
                           input bit r1, input logic [AW-1:0] a1, input bit w);
        st_sel[d][0] = r0; st_rd[d][0] = r0; st_addr[d][0] = a0;
        st_sel[d][1] = r1; st_rd[d][1] = r1; st_addr[d][1] = a1;
        st_wait[d]   = w;
    endtask

    task automatic commit(input int d);
        int    w;
        bit    acc;
        ret_t  h;
        slv_t  s;
        ovec_t o;
        w   = win_of(d);
        acc = (w >= 0) && !st_wait[d];
        o   = observe(d);
        if (!rstn) begin
            prio[d] = 0;
            if (d == 0) rq0.delete(); else rq1.delete();
        end else begin
            if (d == 0 && rq0.size() > 0 && rq0[0].due == cyc) void'(rq0.pop_front());
            if (d == 1 && rq1.size() > 0 && rq1[0].due == cyc) void'(rq1.pop_front());
            if (acc) begin
                h.due = cyc + lat_of(d); h.id = w; h.data = mem_word(st_addr[d][w]);
                if (d == 0) rq0.push_back(h); else rq1.push_back(h);
                prio[d] = 1 - w;
            end
        end
        // The slave answers whatever command it actually took, like a real memory.
        if (o[B_RD] && !st_wait[d]) begin
            s.due = cyc + lat_of(d); s.addr = o[B_SL-1 -: AW];
            if (d == 0) sq0.push_back(s); else sq1.push_back(s);
        end
    endtask

    task automatic tick();
        commit(0);
        commit(1);
        @(posedge clk);
        #1;
        cyc++;
        st_rdata[0] = $urandom;
        st_rdata[1] = $urandom;
        if (sq0.size() > 0 && sq0[0].due == cyc) begin st_rdata[0] = mem_word(sq0[0].addr); void'(sq0.pop_front()); end
        if (sq1.size() > 0 && sq1[0].due == cyc) begin st_rdata[1] = mem_word(sq1[0].addr); void'(sq1.pop_front()); end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) set_req(d, 1'b1, 24'd9, 1'b1, 24'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                ovec_t o;
                o = observe(d);
                n_chk++;
                if ({o[B_RD], o[B_SL], o[B_W0], o[B_W1], o[B_V0], o[B_V1]} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL reset_ctl d%0d: got %b want 000000", d, {o[B_RD], o[B_SL], o[B_W0], o[B_W1], o[B_V0], o[B_V1]});
                end
                n_chk++;
                if (o !== expect_vec(d)) begin
                    n_fail++;
                    $display("FAIL reset_vec d%0d cyc %0d: got %h want %h", d, cyc, o, expect_vec(d));
                end
            end
            tick();
        end
        rstn = 1'b1;
        for (int d = 0; d < 2; d++) set_req(d, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_single_read();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_req(0, 1'b1, 24'd5, 1'b0, '0, 1'b0);
            else        set_req(0, 1'b0, '0, 1'b0, '0, 1'b0);
            @(negedge clk);
            n_chk++;
            if (i == 0 && {ma0.WaitRequest, sa.Read, sa.RegAddr} !== {1'b0, 1'b1, 24'd5}) begin
                n_fail++;
                $display("FAIL single_cmd: got %b/%b/%0d want 0/1/5", ma0.WaitRequest, sa.Read, sa.RegAddr);
            end
            if (i == 1 && {ma0.ReadDataValid, ma0.ReadData, ma1.ReadDataValid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
                n_fail++;
                $display("FAIL single_ret: got v0=%b d0=%h v1=%b want 1 deadbeef 0", ma0.ReadDataValid, ma0.ReadData, ma1.ReadDataValid);
            end
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (observe(d) !== expect_vec(d)) begin
                    n_fail++;
                    $display("FAIL single_vec d%0d cyc %0d: got %h want %h", d, cyc, observe(d), expect_vec(d));
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        // One lone M1 read first so that M0 is the favoured master when contention starts.
        set_req(0, 1'b0, '0, 1'b1, 24'd2, 1'b0);
        @(negedge clk);
        n_chk++;
        if (observe(0) !== expect_vec(0)) begin
            n_fail++;
            $display("FAIL contend_pre: got %h want %h", observe(0), expect_vec(0));
        end
        tick();
        for (int i = 0; i < 7; i++) begin
            int       prev;
            logic [3:0] got, want;
            logic [31:0] gd;
            if (i < 6) set_req(0, 1'b1, 24'd1, 1'b1, 24'd2, 1'b0);
            else       set_req(0, 1'b0, '0, 1'b0, '0, 1'b0);
            @(negedge clk);
            prev = (i == 0) ? 1 : (i - 1) % 2;
            got  = {ma0.WaitRequest, ma1.WaitRequest, ma0.ReadDataValid, ma1.ReadDataValid};
            want = {i < 6 && i % 2 == 1, i < 6 && i % 2 == 0, prev == 0, prev == 1};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL contend_ctl i%0d: got %b want %b", i, got, want);
            end
            gd = (prev == 0) ? ma0.ReadData : ma1.ReadData;
            n_chk++;
            if (gd !== mem_word((prev == 0) ? 24'd1 : 24'd2)) begin
                n_fail++;
                $display("FAIL contend_data i%0d: got %h want %h", i, gd, mem_word((prev == 0) ? 24'd1 : 24'd2));
            end
            n_chk++;
            if (observe(0) !== expect_vec(0)) begin
                n_fail++;
                $display("FAIL contend_vec i%0d: got %h want %h", i, observe(0), expect_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 6; i++) begin
            logic [2:0] got, want;
            case (i)
                0, 1, 2: set_req(0, 1'b0, '0, 1'b1, 24'd7, 1'b1);
                3:       set_req(0, 1'b0, '0, 1'b1, 24'd7, 1'b0);
                4:       set_req(0, 1'b1, 24'd8, 1'b1, 24'd9, 1'b0);
                default: set_req(0, 1'b0, '0, 1'b0, '0, 1'b0);
            endcase
            @(negedge clk);
            got  = {ma1.WaitRequest, ma0.WaitRequest, ma1.ReadDataValid};
            want = (i < 3) ? 3'b100 : (i == 4) ? 3'b101 : 3'b000;
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL stall_ctl i%0d: got %b want %b", i, got, want);
            end
            if (i == 4) begin
                n_chk++;
                if (ma1.ReadData !== mem_word(24'd7)) begin
                    n_fail++;
                    $display("FAIL stall_data: got %h want %h", ma1.ReadData, mem_word(24'd7));
                end
            end
            n_chk++;
            if (observe(0) !== expect_vec(0)) begin
                n_fail++;
                $display("FAIL stall_vec i%0d: got %h want %h", i, observe(0), expect_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_latency3();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] got, want;
            if (i < 4) set_req(1, 1'b1, 24'd3, 1'b1, 24'd4, 1'b0);
            else       set_req(1, 1'b0, '0, 1'b0, '0, 1'b0);
            @(negedge clk);
            got  = {mb0.ReadDataValid, mb1.ReadDataValid};
            want = {i == 3 || i == 5, i == 4 || i == 6};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lat3_valid i%0d: got %b want %b", i, got, want);
            end
            if ((i == 3 && mb0.ReadData !== mem_word(24'd3)) || (i == 4 && mb1.ReadData !== mem_word(24'd4))) begin
                n_fail++;
                $display("FAIL lat3_data i%0d: got %h/%h", i, mb0.ReadData, mb1.ReadData);
            end
            n_chk++;
            if (observe(1) !== expect_vec(1)) begin
                n_fail++;
                $display("FAIL lat3_vec i%0d: got %h want %h", i, observe(1), expect_vec(1));
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (i == 0) set_req(d, 1'b1, 24'd11, 1'b0, '0, 1'b0);
                else        set_req(d, 1'b0, '0, 1'b0, '0, 1'b0);
            end
            rstn = (i == 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                ovec_t o;
                o = observe(d);
                if (i > 0) begin
                    n_chk++;
                    if ({o[B_V0], o[B_V1]} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL midflight_valid d%0d i%0d: got %b want 00", d, i, {o[B_V0], o[B_V1]});
                    end
                end
                n_chk++;
                if (o !== expect_vec(d)) begin
                    n_fail++;
                    $display("FAIL midflight_vec d%0d i%0d: got %h want %h", d, i, o, expect_vec(d));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 404; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) begin
                    st_sel[d][m]  = (i < 400) && ($urandom_range(0, 3) != 0);
                    st_rd[d][m]   = (i < 400) && ($urandom_range(0, 3) != 0);
                    st_addr[d][m] = AW'($urandom_range(0, 15));
                end
                st_wait[d] = (i < 400) && ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (observe(d) !== expect_vec(d)) begin
                    n_fail++;
                    $display("FAIL random_vec d%0d i%0d: got %h want %h", d, i, observe(d), expect_vec(d));
                end
            end
            tick();
        end
    endtask

    initial begin
        rstn   = 1'b0;
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        prio   = '{0, 0};
        for (int d = 0; d < 2; d++) begin
            set_req(d, 1'b0, '0, 1'b0, '0, 1'b0);
            st_rdata[d] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_stall();
        test_latency3();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
